// File: rtl/sd_tag_demux_if.sv
// Bundles the upstream beat stream and per-destination streams of the tag demux.
// master drives beats and destination ready; slave is the demux itself.
interface sd_tag_demux_if #(
  parameter int unsigned width     = 8,
  parameter int unsigned outputs   = 4,
  parameter int unsigned errcnt_sz = 8
);
  logic                       c_srdy;
  logic                       c_drdy;
  logic [width-1:0]           c_data;
  logic [outputs-1:0]         p_srdy;
  logic [outputs-1:0]         p_drdy;
  logic [outputs*width-1:0]   p_data;
  logic [errcnt_sz-1:0]       drop_cnt;

  modport master (
    output c_srdy, c_data, p_drdy,
    input  c_drdy, p_srdy, p_data, drop_cnt
  );

  modport slave (
    input  c_srdy, c_data, p_drdy,
    output c_drdy, p_srdy, p_data, drop_cnt
  );
endinterface

// File: rtl/sd_tag_demux.sv
// Routes each upstream beat to a destination chosen by a tag field in the data word.
// Every destination owns a 2-entry buffer so one stalled port never blocks the others.
module sd_tag_demux #(
  parameter int unsigned width     = 8,
  parameter int unsigned outputs   = 4,
  parameter int unsigned tag_lsb   = 6,
  parameter int unsigned tag_sz    = 2,
  parameter int unsigned errcnt_sz = 8
) (
  input  logic          clk,
  input  logic          reset,
  sd_tag_demux_if.slave bus
);

  logic [tag_sz-1:0]    w_tag;
  logic                 w_tag_ok;
  logic                 w_full;
  logic                 w_xfer;
  logic                 w_drop;
  logic [outputs-1:0]   w_push;
  logic [outputs-1:0]   w_pop;

  logic [width-1:0]     r_head [outputs];
  logic [width-1:0]     r_tail [outputs];
  logic [1:0]           r_cnt  [outputs];
  logic [errcnt_sz-1:0] r_drop;

  assign w_tag    = bus.c_data[tag_lsb +: tag_sz];
  assign w_tag_ok = (32'(w_tag) < outputs);

  // Ready looks only at registered occupancy, never at p_drdy.
  always_comb begin
    w_full = 1'b0;
    for (int unsigned i = 0; i < outputs; i++) begin
      if ((32'(w_tag) == i) && (r_cnt[i] == 2'd2)) w_full = 1'b1;
    end
  end

  assign bus.c_drdy = ~w_tag_ok | ~w_full;
  assign w_xfer     = bus.c_srdy & bus.c_drdy & w_tag_ok;
  assign w_drop     = bus.c_srdy & ~w_tag_ok;

  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int unsigned i = 0; i < outputs; i++) begin
      w_push[i] = w_xfer && (32'(w_tag) == i);
      w_pop[i]  = (r_cnt[i] != 2'd0) && bus.p_drdy[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < outputs; i++) begin
        r_cnt[i]  <= 2'd0;
        r_head[i] <= '0;
        r_tail[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < outputs; i++) begin
        case (r_cnt[i])
          2'd0: begin
            if (w_push[i]) begin
              r_head[i] <= bus.c_data;
              r_cnt[i]  <= 2'd1;
            end
          end
          2'd1: begin
            if (w_push[i] && w_pop[i]) begin
              r_head[i] <= bus.c_data;
            end else if (w_push[i]) begin
              r_tail[i] <= bus.c_data;
              r_cnt[i]  <= 2'd2;
            end else if (w_pop[i]) begin
              r_cnt[i]  <= 2'd0;
            end
          end
          2'd2: begin
            if (w_pop[i]) begin
              r_head[i] <= r_tail[i];
              r_cnt[i]  <= 2'd1;
            end
          end
          default: r_cnt[i] <= 2'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != '1)) begin
      r_drop <= r_drop + errcnt_sz'(1);
    end
  end

  always_comb begin
    bus.p_srdy = '0;
    bus.p_data = '0;
    for (int unsigned i = 0; i < outputs; i++) begin
      bus.p_srdy[i]                = (r_cnt[i] != 2'd0);
      bus.p_data[i*width +: width] = r_head[i];
    end
  end

  assign bus.drop_cnt = r_drop;

endmodule

// File: tb/tb_sd_tag_demux.sv
// Scoreboarded bench for sd_tag_demux: per-port expected queues plus a 3-port
// instance for invalid-tag dropping.
module tb_sd_tag_demux;

  logic clk;
  logic rst_n;

  sd_tag_demux_if #(.width(8), .outputs(4), .errcnt_sz(8)) bus  ();
  sd_tag_demux_if #(.width(8), .outputs(3), .errcnt_sz(8)) bus3 ();

  sd_tag_demux #(
    .width(8), .outputs(4), .tag_lsb(6), .tag_sz(2), .errcnt_sz(8)
  ) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  sd_tag_demux #(
    .width(8), .outputs(3), .tag_lsb(6), .tag_sz(2), .errcnt_sz(8)
  ) u_dut3 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks;
  int         n_errs;
  logic [7:0] sb [4][$];
  logic       acc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock of the 4-port DUT: compare against the scoreboard, then advance it.
  task automatic step();
    logic [1:0] t;
    logic       exp_drdy;
    logic [3:0] exp_srdy;
    logic [3:0] pops;
    logic [7:0] d;
    @(negedge clk);
    t        = bus.c_data[7:6];
    d        = bus.c_data;
    exp_drdy = (sb[t].size() != 2);
    chk("c_drdy", 64'(bus.c_drdy), 64'(exp_drdy));
    for (int i = 0; i < 4; i++) exp_srdy[i] = (sb[i].size() != 0);
    chk("p_srdy", 64'(bus.p_srdy), 64'(exp_srdy));
    for (int i = 0; i < 4; i++) begin
      if (exp_srdy[i]) chk($sformatf("p_data%0d", i), 64'(bus.p_data[i*8 +: 8]), 64'(sb[i][0]));
    end
    acc  = bus.c_srdy && exp_drdy;
    pops = exp_srdy & bus.p_drdy;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (pops[i]) void'(sb[i].pop_front());
    end
    if (acc) sb[t].push_back(d);
    #1;
  endtask

  task automatic send(input logic [7:0] d, output int n);
    bus.c_srdy = 1'b1;
    bus.c_data = d;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc && n < 50);
    chk("send_accept", 64'(acc), 64'(1));
    bus.c_srdy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         d3;
    logic [7:0] pat [4];
    n_checks = 0;
    n_errs   = 0;
    pat[0] = 8'h0F; pat[1] = 8'hF0; pat[2] = 8'h5A; pat[3] = 8'hA5;

    rst_n       = 1'b0;
    bus.c_srdy  = 1'b0;
    bus.c_data  = 8'hC0;
    bus.p_drdy  = 4'hF;
    bus3.c_srdy = 1'b0;
    bus3.c_data = 8'h00;
    bus3.p_drdy = 3'h7;
    #3;
    chk("rst_c_drdy", 64'(bus.c_drdy), 64'(1));
    chk("rst_p_srdy", 64'(bus.p_srdy), 64'(0));
    chk("rst_p_data", 64'(bus.p_data), 64'(0));
    chk("rst_drop", 64'(bus.drop_cnt), 64'(0));
    chk("rst3_p_srdy", 64'(bus3.p_srdy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat to port 2, one-cycle pulse.
    send(8'h85, n);
    chk("single_lat", 64'(n), 64'(1));
    repeat (3) step();

    // Back-pressure fill on port 1.
    bus.p_drdy = 4'b1101;
    send(8'h41, n);
    send(8'h42, n);
    bus.c_srdy = 1'b1;
    bus.c_data = 8'h43;
    repeat (3) step();
    chk("bp_third_blocked", 64'(acc), 64'(0));
    bus.p_drdy = 4'hF;
    send(8'h43, n);
    repeat (4) step();
    chk("bp_drained", 64'(bus.p_srdy), 64'(0));

    // Head-of-line isolation: port 3 full, port 0 still flows.
    bus.p_drdy = 4'b0111;
    send(8'hC1, n);
    send(8'hC2, n);
    send(8'h05, n);
    chk("hol_lat", 64'(n), 64'(1));
    step();
    chk("hol_srdy", 64'(bus.p_srdy), 64'(4'b1000));
    bus.p_drdy = 4'hF;
    repeat (4) step();

    // Push and pop in the same cycle at count 1.
    send(8'h01, n);
    send(8'h02, n);
    chk("pp_lat", 64'(n), 64'(1));
    repeat (3) step();

    // Random traffic over several srdy patterns, with a reset mid-run.
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 300; c++) begin
        bus.c_srdy = pat[p][c%8];
        bus.c_data = 8'($urandom);
        bus.p_drdy = 4'($urandom);
        step();
        if (p == 2 && c == 150) begin
          #2;
          rst_n = 1'b0;
          #1;
          chk("midrst_p_srdy", 64'(bus.p_srdy), 64'(0));
          chk("midrst_p_data", 64'(bus.p_data), 64'(0));
          for (int i = 0; i < 4; i++) sb[i].delete();
          bus.c_srdy = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          @(posedge clk);
          #1;
        end
      end
    end
    bus.c_srdy = 1'b0;
    bus.p_drdy = 4'hF;
    repeat (4) step();
    chk("rand_drop", 64'(bus.drop_cnt), 64'(0));

    // Invalid tag on the 3-port instance: accepted, discarded, counter saturates.
    d3 = 0;
    bus3.c_srdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      bus3.c_data = 8'hC0 | 8'($urandom_range(0, 63));
      @(negedge clk);
      chk("inv_drdy", 64'(bus3.c_drdy), 64'(1));
      chk("inv_srdy", 64'(bus3.p_srdy), 64'(0));
      chk("inv_cnt", 64'(bus3.drop_cnt), 64'(d3));
      @(posedge clk);
      if (d3 != 255) d3++;
      #1;
    end
    bus3.c_srdy = 1'b0;
    @(negedge clk);
    chk("inv_sat", 64'(bus3.drop_cnt), 64'(8'hFF));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
